// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access stage that sits after execute. It accepts one LDR/STR
//   (word or byte, pre/post-indexed, up/down) per handshake, computes the
//   effective address, runs the access on the word-addressed memory bus and
//   returns load data and base-register updates on a register write port.
//   Byte stores use read-modify-write. Only one op is in flight at a time.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   req_valid / req_ready   op handshake (ready only while idle)
//   req_load, req_byte      load/store and byte/word select
//   req_pre, req_up, req_wb addressing mode and base write-back request
//   req_base, req_offset    Rn value and offset used for the effective address
//   req_sdata               store data (Rd value)
//   req_rd, req_rn          load destination and base register indices
//   mem_addr, mem_wdata     word address and write data to memory
//   mem_rdata, mem_abort    read data and abort, both valid in the RESP cycle
//   mem_write, mem_size     write strobe and size (1 = word) during a transfer
//   mem_prot, mem_trans     fixed data-access protection; 2'b10 marks a transfer
//   wb_valid, wb_idx, wb_data  register-file write port
//   done, abort_o           end-of-op pulse and abort indication
module load_store_unit #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_byte,
    input  logic              req_pre,
    input  logic              req_up,
    input  logic              req_wb,
    input  logic [DATA_W-1:0] req_base,
    input  logic [DATA_W-1:0] req_offset,
    input  logic [DATA_W-1:0] req_sdata,
    input  logic [IDX_W-1:0]  req_rd,
    input  logic [IDX_W-1:0]  req_rn,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_abort,
    output logic              mem_write,
    output logic              mem_size,
    output logic [1:0]        mem_prot,
    output logic [1:0]        mem_trans,
    output logic              wb_valid,
    output logic [IDX_W-1:0]  wb_idx,
    output logic [DATA_W-1:0] wb_data,
    output logic              done,
    output logic              abort_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACC, S_RESP, S_WB_RD, S_WR, S_WB_BASE
    } state_t;

    state_t state_q, state_d;

    logic              load_q, byte_q, upd_q;
    logic [1:0]        lane_q;
    logic [DATA_W-1:0] addr_q, ea_q, sdata_q, rdata_q;
    logic [IDX_W-1:0]  rd_q, rn_q;

    logic              accept;
    logic [DATA_W-1:0] ea, acc_addr;
    logic              upd;

    // Rotate a word right by whole bytes (unaligned word load).
    function automatic logic [DATA_W-1:0] rot_bytes(input logic [DATA_W-1:0] w,
                                                    input logic [1:0] lane);
        logic [2*DATA_W-1:0] dbl;
        dbl = {w, w} >> {lane, 3'b000};
        return dbl[DATA_W-1:0];
    endfunction

    // Zero-extended byte at the given little-endian lane.
    function automatic logic [DATA_W-1:0] get_byte(input logic [DATA_W-1:0] w,
                                                   input logic [1:0] lane);
        logic [DATA_W-1:0] sh;
        sh = w >> {lane, 3'b000};
        return {{(DATA_W-8){1'b0}}, sh[7:0]};
    endfunction

    // Replace one byte lane of a word (read-modify-write merge).
    function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] w,
                                                   input logic [7:0] b,
                                                   input logic [1:0] lane);
        logic [DATA_W-1:0] mask;
        mask = {{(DATA_W-8){1'b0}}, 8'hFF} << {lane, 3'b000};
        return (w & ~mask) | ({{(DATA_W-8){1'b0}}, b} << {lane, 3'b000});
    endfunction

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign ea        = req_up ? (req_base + req_offset) : (req_base - req_offset);
    assign acc_addr  = req_pre ? ea : req_base;
    // A load into the base register itself suppresses the base update.
    assign upd       = (!req_pre || req_wb) && !(req_load && (req_rd == req_rn));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Bus address is reset so the idle bus reads zero after reset.
    always_ff @(posedge clk) begin
        if (reset)       addr_q <= '0;
        else if (accept) addr_q <= {2'b00, acc_addr[DATA_W-1:2]};
    end

    // Request capture and read-data capture in RESP
    always_ff @(posedge clk) begin
        if (accept) begin
            load_q  <= req_load;
            byte_q  <= req_byte;
            upd_q   <= upd;
            lane_q  <= acc_addr[1:0];
            ea_q    <= ea;
            sdata_q <= req_sdata;
            rd_q    <= req_rd;
            rn_q    <= req_rn;
        end
        if (state_q == S_RESP) rdata_q <= mem_rdata;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_ACC;
            S_ACC:     state_d = S_RESP;
            S_RESP: begin
                if (mem_abort)   state_d = S_IDLE;
                else if (load_q) state_d = S_WB_RD;
                else if (byte_q) state_d = S_WR;
                else if (upd_q)  state_d = S_WB_BASE;
                else             state_d = S_IDLE;
            end
            S_WB_RD,
            S_WR:      state_d = upd_q ? S_WB_BASE : S_IDLE;
            S_WB_BASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_size  = 1'b0;
        mem_prot  = 2'b01;
        mem_trans = 2'b00;
        wb_valid  = 1'b0;
        wb_idx    = '0;
        wb_data   = '0;
        done      = 1'b0;
        abort_o   = 1'b0;
        case (state_q)
            S_ACC: begin
                mem_trans = 2'b10;
                mem_size  = !byte_q;
                // Only a word store writes here; everything else reads first.
                if (!load_q && !byte_q) begin
                    mem_write = 1'b1;
                    mem_wdata = sdata_q;
                end
            end
            S_RESP: begin
                if (mem_abort) begin
                    done    = 1'b1;
                    abort_o = 1'b1;
                end else if (!load_q && !byte_q && !upd_q) begin
                    done = 1'b1;
                end
            end
            S_WR: begin
                mem_trans = 2'b10;
                mem_write = 1'b1;
                mem_wdata = put_byte(rdata_q, sdata_q[7:0], lane_q);
                done      = !upd_q;
            end
            S_WB_RD: begin
                wb_valid = 1'b1;
                wb_idx   = rd_q;
                wb_data  = byte_q ? get_byte(rdata_q, lane_q) : rot_bytes(rdata_q, lane_q);
                done     = !upd_q;
            end
            S_WB_BASE: begin
                wb_valid = 1'b1;
                wb_idx   = rn_q;
                wb_data  = ea_q;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit. A word-addressed memory responder
//   serves the bus; a per-op model derives the expected cycle-by-cycle bus,
//   write-back and done activity from the addressing rules and latency table,
//   and a compare process checks the DUT against it every cycle of each op.
//   Literal expectations pin the main examples independently of the model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic        req_load, req_byte, req_pre, req_up, req_wb;
    logic [31:0] req_base, req_offset, req_sdata;
    logic [3:0]  req_rd, req_rn;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_abort, mem_write, mem_size;
    logic [1:0]  mem_prot, mem_trans;
    logic        wb_valid;
    logic [3:0]  wb_idx;
    logic [31:0] wb_data;
    logic        done, abort_o;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_W(32), .IDX_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_byte(req_byte), .req_pre(req_pre),
        .req_up(req_up), .req_wb(req_wb),
        .req_base(req_base), .req_offset(req_offset), .req_sdata(req_sdata),
        .req_rd(req_rd), .req_rn(req_rn),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_abort(mem_abort), .mem_write(mem_write), .mem_size(mem_size),
        .mem_prot(mem_prot), .mem_trans(mem_trans),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
        .done(done), .abort_o(abort_o)
    );

    typedef struct {
        bit          load, byt, pre, up, wb, abt;
        logic [31:0] base, off, sdata;
        logic [3:0]  rd, rn;
    } op_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // Memory responder
    logic [31:0] mem [logic [31:0]];
    bit          abort_nxt = 1'b0;

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    initial begin
        mem_rdata = 32'h0;
        mem_abort = 1'b0;
        forever begin
            @(posedge clk);
            if (mem_trans == 2'b10 && mem_write) mem[mem_addr] = mem_wdata;
            mem_rdata <= (mem_trans == 2'b10 && !mem_write) ? rd_mem(mem_addr) : 32'h0;
            mem_abort <= (mem_trans == 2'b10) ? abort_nxt : 1'b0;
        end
    end

    // Expected activity per cycle after the accept edge (index 1..e_last)
    logic [1:0]  e_trans [8];
    bit          e_write [8], e_size [8], e_wbv [8], e_done [8], e_abt [8];
    logic [31:0] e_addr  [8], e_wdata [8], e_wbd [8];
    logic [3:0]  e_idx   [8];
    int          e_last;

    task automatic build_exp(input op_t op);
        logic [31:0] ea, acc, wa, old, dbl_lo, ext;
        logic [63:0] dbl;
        int          sh, n;
        bit          upd;
        for (int i = 0; i < 8; i++) begin
            e_trans[i] = 2'b00; e_write[i] = 0; e_size[i] = 0; e_wbv[i] = 0;
            e_done[i] = 0; e_abt[i] = 0; e_addr[i] = 0; e_wdata[i] = 0;
            e_wbd[i] = 0; e_idx[i] = 0;
        end
        ea  = op.up ? op.base + op.off : op.base - op.off;
        acc = op.pre ? ea : op.base;
        wa  = acc / 4;
        sh  = 8 * (acc % 4);
        upd = (!op.pre || op.wb) && !(op.load && op.rd == op.rn);
        old = rd_mem(wa);
        e_trans[1] = 2'b10;
        e_addr[1]  = wa;
        e_size[1]  = !op.byt;
        e_write[1] = !op.load && !op.byt;
        e_wdata[1] = op.sdata;
        if (op.abt) begin
            e_done[2] = 1; e_abt[2] = 1; e_last = 2;
        end else begin
            n = 2;
            if (op.load) begin
                n = 3;
                dbl = {old, old} >> sh;
                dbl_lo = dbl[31:0];
                ext = (old >> sh) & 32'hFF;
                e_wbv[3] = 1; e_idx[3] = op.rd;
                e_wbd[3] = op.byt ? ext : dbl_lo;
            end else if (op.byt) begin
                n = 3;
                e_trans[3] = 2'b10; e_write[3] = 1; e_addr[3] = wa; e_size[3] = 0;
                e_wdata[3] = (old & ~(32'hFF << sh)) | ((op.sdata & 32'hFF) << sh);
            end
            if (upd) begin
                n++;
                e_wbv[n] = 1; e_idx[n] = op.rn; e_wbd[n] = ea;
            end
            e_done[n] = 1;
            e_last = n;
        end
    endtask

    // Compare process plus an observation log for literal checks
    int          op_seq = 0, seen_seq = 0, fin_seq = 0;
    int          k = 0;
    bit          active = 0;
    int          lg_n = 0, lg_k [8], dn_cnt = 0, dn_k = 0;
    logic [3:0]  lg_idx [8];
    logic [31:0] lg_dat [8];

    initial begin
        forever begin
            @(negedge clk);
            if (op_seq != seen_seq) begin
                seen_seq = op_seq; k = 0; active = 1; lg_n = 0; dn_cnt = 0; dn_k = 0;
            end
            if (active) begin
                k++;
                if (wb_valid && lg_n < 8) begin
                    lg_k[lg_n] = k; lg_idx[lg_n] = wb_idx; lg_dat[lg_n] = wb_data; lg_n++;
                end
                if (done) begin dn_cnt++; dn_k = k; end
                chk("mem_prot", {30'b0, mem_prot}, 32'h1);
                if (k <= e_last) begin
                    chk("req_ready_busy", {31'b0, req_ready}, 32'h0);
                    chk("mem_trans", {30'b0, mem_trans}, {30'b0, e_trans[k]});
                    if (e_trans[k] == 2'b10) begin
                        chk("mem_write", {31'b0, mem_write}, {31'b0, e_write[k]});
                        chk("mem_addr", mem_addr, e_addr[k]);
                        chk("mem_size", {31'b0, mem_size}, {31'b0, e_size[k]});
                        if (e_write[k]) chk("mem_wdata", mem_wdata, e_wdata[k]);
                    end
                    chk("wb_valid", {31'b0, wb_valid}, {31'b0, e_wbv[k]});
                    if (e_wbv[k]) begin
                        chk("wb_idx", {28'b0, wb_idx}, {28'b0, e_idx[k]});
                        chk("wb_data", wb_data, e_wbd[k]);
                    end
                    chk("done", {31'b0, done}, {31'b0, e_done[k]});
                    chk("abort_o", {31'b0, abort_o}, {31'b0, e_abt[k]});
                end else begin
                    chk("req_ready_after", {31'b0, req_ready}, 32'h1);
                    chk("trans_after", {30'b0, mem_trans}, 32'h0);
                    chk("wb_after", {31'b0, wb_valid}, 32'h0);
                    chk("done_after", {31'b0, done}, 32'h0);
                    active = 0;
                    fin_seq = seen_seq;
                end
            end
        end
    end

    task automatic run_op(input op_t op);
        build_exp(op);
        @(posedge clk); #1;
        req_load = op.load; req_byte = op.byt; req_pre = op.pre; req_up = op.up;
        req_wb = op.wb; req_base = op.base; req_offset = op.off; req_sdata = op.sdata;
        req_rd = op.rd; req_rn = op.rn; abort_nxt = op.abt;
        req_valid = 1'b1;
        @(posedge clk); #1;
        op_seq++;
        // Keep offering a different op while busy; it must be ignored.
        req_load = !op.load; req_byte = !op.byt; req_pre = !op.pre; req_up = !op.up;
        req_wb = !op.wb; req_base = ~op.base; req_offset = ~op.off; req_sdata = ~op.sdata;
        req_rd = ~op.rd; req_rn = ~op.rn;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 20 && fin_seq != op_seq; i++) @(negedge clk);
        if (fin_seq != op_seq) chk("op_timeout", 32'h0, 32'h1);
        abort_nxt = 1'b0;
        #1;
    endtask

    function automatic op_t mk(input bit load, input bit byt, input bit pre, input bit up,
                               input bit wb, input logic [31:0] base, input logic [31:0] off,
                               input logic [31:0] sdata, input logic [3:0] rd,
                               input logic [3:0] rn);
        op_t o;
        o.load = load; o.byt = byt; o.pre = pre; o.up = up; o.wb = wb; o.abt = 0;
        o.base = base; o.off = off; o.sdata = sdata; o.rd = rd; o.rn = rn;
        return o;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'h1);
        chk({tag, "_trans"}, {30'b0, mem_trans}, 32'h0);
        chk({tag, "_write"}, {31'b0, mem_write}, 32'h0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_size"}, {31'b0, mem_size}, 32'h0);
        chk({tag, "_wbv"}, {31'b0, wb_valid}, 32'h0);
        chk({tag, "_wbidx"}, {28'b0, wb_idx}, 32'h0);
        chk({tag, "_wbdata"}, wb_data, 32'h0);
        chk({tag, "_done"}, {31'b0, done}, 32'h0);
        chk({tag, "_abort"}, {31'b0, abort_o}, 32'h0);
    endtask

    initial begin
        op_t o;
        reset = 1'b1; req_valid = 1'b0;
        req_load = 0; req_byte = 0; req_pre = 0; req_up = 0; req_wb = 0;
        req_base = 0; req_offset = 0; req_sdata = 0; req_rd = 0; req_rn = 0;
        mem[32'h41] = 32'hAABBCCDD;
        mem[32'h40] = 32'h11223344;
        mem[32'h80] = 32'h11223344;
        mem[32'h103] = 32'h12345678;
        mem[32'h140] = 32'hA1B2C3D4;
        mem[32'h1C0] = 32'h00000000;
        mem[32'h3FFFFFFF] = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b0;

        // LDR word, pre, up, no write-back
        run_op(mk(1, 0, 1, 1, 0, 32'h100, 32'h4, 32'h0, 4'd1, 4'd2));
        chk("t1_wbcount", lg_n, 1);
        chk("t1_wbcycle", lg_k[0], 3);
        chk("t1_wbidx", {28'b0, lg_idx[0]}, 32'h1);
        chk("t1_wbdata", lg_dat[0], 32'hAABBCCDD);
        chk("t1_donecount", dn_cnt, 1);

        // LDRB post-indexed, down
        run_op(mk(1, 1, 0, 0, 0, 32'h103, 32'h8, 32'h0, 4'd3, 4'd4));
        chk("t2_wbcount", lg_n, 2);
        chk("t2_rd", lg_dat[0], 32'h11);
        chk("t2_rdcycle", lg_k[0], 3);
        chk("t2_rnidx", {28'b0, lg_idx[1]}, 32'h4);
        chk("t2_rn", lg_dat[1], 32'hFB);
        chk("t2_rncycle", lg_k[1], 4);

        // STRB lane 1, read-modify-write
        run_op(mk(0, 1, 1, 1, 0, 32'h201, 32'h0, 32'h000000EE, 4'd5, 4'd6));
        chk("t3_mem", rd_mem(32'h80), 32'h1122EE44);
        chk("t3_donecycle", dn_k, 3);

        // STR word aborted in RESP; write-back request must be dropped
        o = mk(0, 0, 1, 1, 1, 32'h300, 32'h0, 32'hDEADBEEF, 4'd7, 4'd8);
        o.abt = 1;
        run_op(o);
        chk("t4_donecycle", dn_k, 2);
        chk("t4_nowb", lg_n, 0);

        // LDR with rd == rn and write-back: only the loaded value is written
        run_op(mk(1, 0, 1, 1, 1, 32'h400, 32'hC, 32'h0, 4'd5, 4'd5));
        chk("t5_wbcount", lg_n, 1);
        chk("t5_wbdata", lg_dat[0], 32'h12345678);

        // Unaligned LDR word, lane 2 rotation
        run_op(mk(1, 0, 1, 1, 0, 32'h502, 32'h0, 32'h0, 4'd9, 4'd10));
        chk("t6_rot", lg_dat[0], 32'hC3D4A1B2);

        // STR word with pre-index write-back
        run_op(mk(0, 0, 1, 1, 1, 32'h600, 32'h10, 32'h55AA33CC, 4'd11, 4'd12));
        chk("t7_mem", rd_mem(32'h184), 32'h55AA33CC);
        chk("t7_rn", lg_dat[0], 32'h610);

        // STRB post-indexed lane 3 with base update
        run_op(mk(0, 1, 0, 1, 0, 32'h703, 32'h1, 32'h1234565A, 4'd13, 4'd14));
        chk("t8_mem", rd_mem(32'h1C0), 32'h5A000000);
        chk("t8_donecycle", dn_k, 4);

        // Down-counting address wrap below zero
        run_op(mk(1, 0, 1, 0, 1, 32'h0, 32'h4, 32'h0, 4'd1, 4'd15));
        chk("t9_ld", lg_dat[0], 32'hCAFEF00D);
        chk("t9_rn", lg_dat[1], 32'hFFFFFFFC);

        // Reset during RESP of a load abandons it
        @(posedge clk); #1;
        req_load = 1; req_byte = 0; req_pre = 1; req_up = 1; req_wb = 0;
        req_base = 32'h100; req_offset = 32'h4; req_rd = 4'd6; req_rn = 4'd2;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_acc_trans", {30'b0, mem_trans}, 32'h2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_idle("rst_mid");
        @(posedge clk); #1;
        chk("rst_after_wbv", {31'b0, wb_valid}, 32'h0);
        chk("rst_after_done", {31'b0, done}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
